cp0_int_ctrl: RTL and testbench
===============================

Name: cp0_int_ctrl

Overview:
- CPU-side coprocessor-0 block; the receiving end of peripheral interrupt lines such as the timer IRQ.
- Holds SR (reg 12), Cause (reg 13), EPC (reg 14) and PRId (reg 15).
- Arbitrates hardware interrupts and internal exceptions at the M stage.
- Raises `req` to flush the pipeline and redirect fetch; `eret` returns to `epc_out`.

Parameters:
- PRID, 32'h0000_0001, constant returned on reads of reg 15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- we  in  1  mtc0 write strobe (M stage)
- addr  in  5  CP0 register number for read and write
- din  in  32  mtc0 write data
- dout  out  32  mfc0 read data (combinational)
- pc  in  32  PC of the M-stage instruction, word aligned
- bd_in  in  1  M-stage instruction is in a branch delay slot
- exc_code_in  in  5  internal exception code; 0 = none
- hw_int  in  6  device interrupt lines; bit 0 = timer 0, bit 1 = timer 1, bit 2 = external
- eret  in  1  M-stage instruction is eret
- req  out  1  take exception/interrupt this cycle (combinational)
- exl  out  1  SR.EXL
- epc_out  out  32  EPC value for eret redirect

Behaviour:
- SR fields:
  - IM = [15:10], EXL = [1], IE = [0]; all other bits read 0.
  - Reset: SR = 0.
- Cause fields:
  - BD = [31], IP = [15:10], ExcCode = [6:2]; all other bits read 0.
  - Reset: Cause = 0.
- EPC: 32 bits, [1:0] always 0. Reset: EPC = 0.
- Reset values of outputs: req = 0 (since SR = 0), exl = 0, epc_out = 0, dout per addr.
- Combinational request logic:
  - int_req = |(hw_int & SR.IM) & SR.IE & ~SR.EXL
  - exc_req = (exc_code_in != 0) & ~SR.EXL
  - req = int_req | exc_req
- Priority: an interrupt beats an internal exception; ExcCode = 0 for an interrupt, else exc_code_in.
- On posedge with req = 1 and no reset:
  - SR.EXL <= 1
  - Cause.BD <= bd_in
  - Cause.ExcCode <= code
  - EPC <= bd_in ? pc - 4 : pc
  - Any mtc0 write in the same cycle is discarded.
- Cause.IP <= hw_int on every non-reset posedge, regardless of masks or EXL. IP therefore lags hw_int by one cycle.
- mtc0 writes (we = 1, req = 0):
  - SR: writes IM, EXL, IE from the same bit positions of din.
  - Cause: read-only; write ignored.
  - EPC: EPC <= {din[31:2], 2'b00}.
  - PRId and unimplemented registers: write ignored.
- eret = 1 and req = 0: SR.EXL <= 0.
  - If we targets SR in the same cycle, eret's EXL = 0 overrides din[1]; the IM/IE bits of din still apply.
- eret and req together (only possible with EXL = 0): req wins; EXL becomes 1.
- Reads: dout = SR / Cause / EPC / PRID for addr 12 / 13 / 14 / 15, else 0.
  - Reads reflect register state before the current edge; there is no write-to-read bypass.
- epc_out = EPC register.
- Nesting: while EXL = 1, both interrupts and exceptions are masked. A pending hw_int fires the cycle after eret clears EXL, provided IE and IM allow it.
- Reset mid-handler: everything returns to zero and req deasserts immediately.
- Level-sensitive: the block does not clear device IRQs; software must acknowledge at the device.

Optional Feature:
- Macro: CP0_EPC_BYPASS_EN.
- Defined: when we = 1, addr = 14 and req = 0, epc_out = {din[31:2], 2'b00} combinationally in that cycle. This covers mtc0 EPC immediately followed by eret.
- Not defined: epc_out is always the EPC register; the new value appears after the posedge.

Test Plan:
- Reset check: after reset, dout = 0 for addr 12/13/14, dout = PRID for addr 15, req = 0, exl = 0.
- Timer interrupt: mtc0 SR = 32'h0000_0401 (IM[10] = 1, IE = 1); pc = 32'h0000_3010, bd_in = 0; raise hw_int = 6'b000001.
  - Required: req = 1 the same cycle.
  - Next cycle: exl = 1, EPC = 32'h0000_3010, Cause ExcCode = 0, IP = 6'b000001; req = 0 while EXL = 1.
- Delay-slot exception: exc_code_in = 5'd10, bd_in = 1, pc = 32'h0000_3024, SR = 0.
  - Required: req = 1; afterwards EPC = 32'h0000_3020, Cause = 32'h8000_0028 (IP = 0 assumes hw_int = 0).
- Priority: hw_int[0] enabled and exc_code_in = 5'd4 in the same cycle.
  - Required: ExcCode = 0; mtc0 EPC issued that cycle is discarded.
- eret plus mtc0 SR in the same cycle: EXL = 1, eret = 1, we = 1, addr = 12, din = 32'h0000_0C03.
  - Required: SR = 32'h0000_0C01.
  - With hw_int[1] high: req = 1 on the following cycle.
- Bypass: mtc0 EPC = 32'h0000_4003.
  - Required with CP0_EPC_BYPASS_EN: epc_out = 32'h0000_4000 the same cycle.
  - Required without the macro: epc_out keeps its old value until after the edge.

Source files
------------

// File: rtl/cp0_int_ctrl.sv
// Coprocessor-0 status/cause/EPC/PRId with M-stage interrupt and exception arbitration; req is combinational, state updates on the edge.
// Optional macro CP0_EPC_BYPASS_EN forwards an mtc0 EPC write straight to epc_out in the same cycle.
module cp0_int_ctrl #(
   parameter logic [31:0] PRID = 32'h0000_0001
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [4:0]  addr,
   input  logic [31:0] din,
   output logic [31:0] dout,
   input  logic [31:0] pc,
   input  logic        bd_in,
   input  logic [4:0]  exc_code_in,
   input  logic [5:0]  hw_int,
   input  logic        eret,
   output logic        req,
   output logic        exl,
   output logic [31:0] epc_out
);
   localparam logic [4:0] REG_SR    = 5'd12;
   localparam logic [4:0] REG_CAUSE = 5'd13;
   localparam logic [4:0] REG_EPC   = 5'd14;
   localparam logic [4:0] REG_PRID  = 5'd15;

   logic [5:0]  im_q;
   logic        exl_q;
   logic        ie_q;
   logic        bd_q;
   logic [5:0]  ip_q;
   logic [4:0]  exc_q;
   logic [31:0] epc_q;

   logic        int_req;
   logic        exc_req;
   logic [4:0]  code;
   logic [31:0] sr_val;
   logic [31:0] cause_val;

   assign int_req = (|(hw_int & im_q)) & ie_q & ~exl_q;
   assign exc_req = (exc_code_in != 5'd0) & ~exl_q;
   assign req     = int_req | exc_req;
   // Interrupts outrank internal exceptions and report ExcCode 0.
   assign code    = int_req ? 5'd0 : exc_code_in;

   always_ff @(posedge clk) begin
      if (reset) begin
         im_q  <= 6'd0;
         exl_q <= 1'b0;
         ie_q  <= 1'b0;
         bd_q  <= 1'b0;
         ip_q  <= 6'd0;
         exc_q <= 5'd0;
         epc_q <= 32'd0;
      end else begin
         ip_q <= hw_int;
         if (req) begin
            exl_q <= 1'b1;
            bd_q  <= bd_in;
            exc_q <= code;
            epc_q <= (bd_in ? pc - 32'd4 : pc) & 32'hFFFF_FFFC;
         end else begin
            if (we && addr == REG_SR) begin
               im_q  <= din[15:10];
               exl_q <= din[1];
               ie_q  <= din[0];
            end
            if (we && addr == REG_EPC) begin
               epc_q <= {din[31:2], 2'b00};
            end
            // eret clears EXL even when mtc0 SR in the same cycle sets it.
            if (eret) begin
               exl_q <= 1'b0;
            end
         end
      end
   end

   assign sr_val    = {16'd0, im_q, 8'd0, exl_q, ie_q};
   assign cause_val = {bd_q, 15'd0, ip_q, 3'd0, exc_q, 2'b00};

   always_comb begin
      dout = 32'd0;
      case (addr)
         REG_SR:    dout = sr_val;
         REG_CAUSE: dout = cause_val;
         REG_EPC:   dout = epc_q;
         REG_PRID:  dout = PRID;
         default:   dout = 32'd0;
      endcase
   end

   assign exl = exl_q;

`ifdef CP0_EPC_BYPASS_EN
   assign epc_out = (we && addr == REG_EPC && !req) ? {din[31:2], 2'b00} : epc_q;
`else
   assign epc_out = epc_q;
`endif
endmodule

// File: tb/tb_cp0_int_ctrl.sv
// Self-checking bench for cp0_int_ctrl: directed test-plan scenarios plus randomized traffic against a word-level model.
module tb_cp0_int_ctrl;
   localparam logic [31:0] PRID = 32'h0000_0001;

   logic        clk;
   logic        reset;
   logic        we;
   logic [4:0]  addr;
   logic [31:0] din;
   logic [31:0] dout;
   logic [31:0] pc;
   logic        bd_in;
   logic [4:0]  exc_code_in;
   logic [5:0]  hw_int;
   logic        eret;
   logic        req;
   logic        exl;
   logic [31:0] epc_out;

   int n_cmp = 0;
   int n_err = 0;

   // Reference state kept as architectural 32-bit words.
   logic [31:0] m_sr, m_cause, m_epc;

   logic [31:0] obs_dout, obs_epc;
   logic        obs_req, obs_exl;

   cp0_int_ctrl #(.PRID(PRID)) dut (
      .clk(clk), .reset(reset), .we(we), .addr(addr), .din(din), .dout(dout),
      .pc(pc), .bd_in(bd_in), .exc_code_in(exc_code_in), .hw_int(hw_int),
      .eret(eret), .req(req), .exl(exl), .epc_out(epc_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic model_int();
      return ((hw_int & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
   endfunction

   function automatic logic model_req();
      return model_int() || (exc_code_in != 5'd0 && !m_sr[1]);
   endfunction

   function automatic logic [31:0] model_dout();
      case (addr)
         5'd12:   return m_sr;
         5'd13:   return m_cause;
         5'd14:   return m_epc;
         5'd15:   return PRID;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] model_epc_out();
`ifdef CP0_EPC_BYPASS_EN
      if (we && addr == 5'd14 && !model_req()) return din & 32'hFFFF_FFFC;
`endif
      return m_epc;
   endfunction

   // One cycle: drive at negedge, check combinational/registered outputs, then advance the model at posedge.
   task automatic step(input logic rst, input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic [31:0] p, input logic bd, input logic [4:0] ec,
                       input logic [5:0] hw, input logic er);
      logic r, ir;
      @(negedge clk);
      reset = rst; we = w; addr = a; din = d; pc = p; bd_in = bd;
      exc_code_in = ec; hw_int = hw; eret = er;
      #1;
      obs_dout = dout; obs_req = req; obs_exl = exl; obs_epc = epc_out;
      r  = model_req();
      ir = model_int();
      if (!rst) chk("req", {31'd0, req}, {31'd0, r});
      chk("exl", {31'd0, exl}, {31'd0, m_sr[1]});
      chk("dout", dout, model_dout());
      chk("epc_out", epc_out, model_epc_out());
      @(posedge clk);
      if (rst) begin
         m_sr = 32'd0; m_cause = 32'd0; m_epc = 32'd0;
      end else begin
         if (r) begin
            m_sr    = m_sr | 32'd2;
            m_cause = (bd ? 32'h8000_0000 : 32'd0) | (32'(ir ? 5'd0 : ec) * 4);
            m_epc   = bd ? p - 32'd4 : p;
         end else begin
            if (w && a == 5'd12) m_sr = d & 32'h0000_FC03;
            if (w && a == 5'd14) m_epc = d & 32'hFFFF_FFFC;
            if (er) m_sr = m_sr & ~32'd2;
         end
         m_cause = (m_cause & ~32'h0000_FC00) | (32'(hw) * 1024);
      end
   endtask

   initial begin
      m_sr = '0; m_cause = '0; m_epc = '0;
      reset = 1'b1; we = 1'b0; addr = 5'd0; din = '0; pc = '0; bd_in = 1'b0;
      exc_code_in = '0; hw_int = '0; eret = 1'b0;
      @(posedge clk);
      m_sr = '0; m_cause = '0; m_epc = '0;

      // Reset state
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 12, 0, 0, 0, 0, 0, 0); chk("rst_sr", obs_dout, 32'd0);
      chk("rst_req", {31'd0, obs_req}, 32'd0); chk("rst_exl", {31'd0, obs_exl}, 32'd0);
      step(0, 0, 13, 0, 0, 0, 0, 0, 0); chk("rst_cause", obs_dout, 32'd0);
      step(0, 0, 14, 0, 0, 0, 0, 0, 0); chk("rst_epc", obs_dout, 32'd0);
      step(0, 0, 15, 0, 0, 0, 0, 0, 0); chk("rst_prid", obs_dout, PRID);

      // Timer interrupt
      step(0, 1, 12, 32'h0000_0401, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 32'h0000_3010, 0, 0, 6'b000001, 0); chk("tmr_req", {31'd0, obs_req}, 32'd1);
      step(0, 0, 14, 0, 32'h0000_3014, 0, 0, 6'b000001, 0);
      chk("tmr_exl", {31'd0, obs_exl}, 32'd1); chk("tmr_epc", obs_dout, 32'h0000_3010);
      chk("tmr_masked", {31'd0, obs_req}, 32'd0);
      step(0, 0, 13, 0, 0, 0, 0, 6'b000001, 0); chk("tmr_cause", obs_dout, 32'h0000_0400);

      // Delay-slot exception
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 32'h0000_3024, 1, 5'd10, 0, 0); chk("ds_req", {31'd0, obs_req}, 32'd1);
      step(0, 0, 14, 0, 0, 0, 0, 0, 0); chk("ds_epc", obs_dout, 32'h0000_3020);
      step(0, 0, 13, 0, 0, 0, 0, 0, 0); chk("ds_cause", obs_dout, 32'h8000_0028);

      // Interrupt beats exception; same-cycle mtc0 EPC discarded
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 12, 32'h0000_0401, 0, 0, 0, 0, 0);
      step(0, 1, 14, 32'h0000_5550, 32'h0000_0100, 0, 5'd4, 6'b000001, 0);
      chk("pri_req", {31'd0, obs_req}, 32'd1);
      step(0, 0, 13, 0, 0, 0, 0, 0, 0); chk("pri_cause", obs_dout, 32'h0000_0400);
      step(0, 0, 14, 0, 0, 0, 0, 0, 0); chk("pri_epc", obs_dout, 32'h0000_0100);

      // eret with mtc0 SR in the same cycle
      step(0, 1, 12, 32'h0000_0C03, 0, 0, 0, 6'b000010, 1); chk("eret_blk", {31'd0, obs_req}, 32'd0);
      step(0, 0, 12, 0, 32'h0000_0200, 0, 0, 6'b000010, 0);
      chk("eret_sr", obs_dout, 32'h0000_0C01); chk("eret_req", {31'd0, obs_req}, 32'd1);

      // mtc0 EPC forwarding
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 14, 32'h0000_4003, 0, 0, 0, 0, 0);
`ifdef CP0_EPC_BYPASS_EN
      chk("byp_same", obs_epc, 32'h0000_4000);
`else
      chk("byp_same", obs_epc, 32'd0);
`endif
      step(0, 0, 0, 0, 0, 0, 0, 0, 0); chk("byp_next", obs_epc, 32'h0000_4000);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic        r_rst, r_we, r_bd, r_er;
         logic [4:0]  r_a, r_ec;
         logic [5:0]  r_hw;
         logic [31:0] r_d, r_p;
         r_rst = ($urandom_range(0, 99) < 2);
         r_we  = ($urandom_range(0, 3) == 0);
         r_a   = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'($urandom_range(12, 15));
         r_d   = $urandom;
         if ($urandom_range(0, 1) == 0) r_d[1] = 1'b0;
         r_p   = $urandom & 32'hFFFF_FFFC;
         r_bd  = $urandom_range(0, 1);
         r_ec  = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'd0;
         r_hw  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
         r_er  = ($urandom_range(0, 5) == 0);
         step(r_rst, r_we, r_a, r_d, r_p, r_bd, r_ec, r_hw, r_er);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
